// File: rtl/lab3_seq_detector.sv
// Moore FSM that detects the serial pattern 1101 (overlapping allowed) and
// keeps a saturating, clearable count of how many times it was found.
module lab3_seq_detector #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             din,
  input  logic             en,
  input  logic             cnt_clr,
  output logic             detect,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S110  = 3'd3,
    FOUND = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] count_r;
  logic             enter_found_s;

  // Next-state decode; unused encodings fall back to S0 even when en is low.
  always_comb begin
    state_next_s = S0;
    case (state_r)
      S0:      state_next_s = en ? (din ? S1    : S0)   : S0;
      S1:      state_next_s = en ? (din ? S11   : S0)   : S1;
      S11:     state_next_s = en ? (din ? S11   : S110) : S11;
      S110:    state_next_s = en ? (din ? FOUND : S0)   : S110;
      FOUND:   state_next_s = en ? (din ? S11   : S0)   : FOUND;
      default: state_next_s = S0;
    endcase
  end

  // A hold in FOUND with en low is not a new entry.
  always_comb begin
    if ((state_next_s == FOUND) && ((state_r != FOUND) || en)) begin
      enter_found_s = 1'b1;
    end else begin
      enter_found_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= S0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Detection counter: clear beats a simultaneous entry, and it never wraps.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      count_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enter_found_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign detect = (state_r == FOUND);
  assign count  = count_r;
  assign state  = state_r;

endmodule

// File: doc/lab3_seq_detector.md
LAB3_SEQ_DETECTOR -- requirements
Module: lab3_seq_detector

Interface
REQ-001 Parameter: CNT_W, default 4, width of the detection counter.
REQ-002 Port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset_b  input  1  asynchronous active-low reset.
REQ-004 Port: din  input  1  serial data bit, driven from the Q output of the upstream positive-edge D flip-flop stage.
REQ-005 Port: en  input  1  sample enable; din is consumed only on edges where en=1.
REQ-006 Port: cnt_clr  input  1  synchronous clear of the detection counter.
REQ-007 Port: detect  output  1  high for exactly the cycle(s) the FSM is in state FOUND.
REQ-008 Port: count  output  CNT_W  number of detections since reset or clear, saturating.
REQ-009 Port: state  output  3  current FSM state encoding, for debug.

Function
REQ-010 The block SHALL be a Moore FSM detecting serial pattern 1101 (first bit first), overlapping occurrences allowed.
REQ-011 State encoding SHALL be: S0=3'd0, S1=3'd1 (seen 1), S11=3'd2 (seen 11), S110=3'd3 (seen 110), FOUND=3'd4 (seen 1101).
REQ-012 Transitions with en=1: S0: din=1->S1, 0->S0; S1: 1->S11, 0->S0; S11: 1->S11, 0->S110; S110: 1->FOUND, 0->S0; FOUND: 1->S11, 0->S0.
REQ-013 Encodings 5-7 SHALL transition to S0 on the next rising edge regardless of en.
REQ-014 With en=0 the state SHALL hold and count SHALL not change.
REQ-015 detect SHALL be combinationally decoded from the state register only (state==FOUND); no dependence on din, en or cnt_clr.
REQ-016 Latency: detect SHALL rise on the same rising edge that samples the final 1 of a 1101 sequence, i.e. one clock after that bit is presented on din.
REQ-017 detect SHALL stay high for more than one cycle if en=0 holds the FSM in FOUND.
REQ-018 count SHALL increment by 1 on each rising edge where the next state is FOUND and the current state is not FOUND or en=1 (every entry into FOUND counts once).
REQ-019 count SHALL saturate at 2^CNT_W-1 (15 for default) and not wrap.
REQ-020 cnt_clr=1 SHALL set count to 0 on the next rising edge; it does not affect state or detect.
REQ-021 Simultaneous cnt_clr=1 and entry into FOUND: clear SHALL win, count=0 after the edge.
REQ-022 din SHALL be treated as already synchronous to clock; no synchronizer inside the block.

Reset
REQ-023 reset_b=0 SHALL immediately, independent of clock, force state=S0, count=0, detect=0.
REQ-024 Reset asserted mid-sequence SHALL discard partial pattern progress; after release, detection restarts from S0.
REQ-025 On the first rising edge after reset_b rises, the FSM SHALL operate normally (no extra wait cycles).

Verification
REQ-026 Reset, en=1, din=1,1,0,1 on four edges -> state 1,2,3,4, detect=1 on the 4th edge, count=1.
REQ-027 Overlap: din=1,1,0,1,1,0,1 -> detect high after edges 4 and 7 only, count=2, state=S11 after edge 5.
REQ-028 Gating: din=1,1,0, then en=0 for 3 edges with din=1, then en=1 with din=1 -> state holds 3, then 4; count=1.
REQ-029 Saturation/clear: 16 repeated 1101 patterns -> count=15 (not 0); cnt_clr=1 on the edge of the 17th FOUND entry -> count=0, detect=1.
REQ-030 Async reset: pull reset_b low 7 time units after an edge while state=S110 -> state=0, count=0, detect=0 without waiting for clock; after release din=1 -> state=S1.
REQ-031 Bench SHALL use a 40-unit clock period (toggle every 20), change din away from clock edges, dump a VCD, and end with $finish.
